buffer_reader: RTL and testbench
================================

Name: buffer_reader

Overview:
- Read-side controller for the activation/weight FIFO buffers.
- On `start`, pops exactly `len` words from one buffer's read port and presents them as a valid/ready stream toward the PE array feeder.
- Absorbs the buffer's 1-cycle registered read latency with a 2-entry output skid, so sustained throughput is one word per cycle under back-pressure.

Parameters:
- DWIDTH, 16, buffer word width and stream data width
- MAX_LEN, 256, largest transfer length accepted
- LEN_W, $clog2(MAX_LEN+1), width of the length field and internal counters

Ports:
- clk  input  1  single clock for the whole block
- rstn  input  1  asynchronous active-low reset
- start  input  1  1-cycle pulse; begins a transfer; ignored while busy
- len  input  LEN_W  word count, sampled with start; 0..MAX_LEN
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  1-cycle pulse when the transfer completes
- buf_rd_en  output  1  read request to the buffer
- buf_dout  input  DWIDTH  buffer read data; valid the cycle after buf_rd_en & !buf_empty
- buf_empty  input  1  buffer empty flag
- m_valid  output  1  stream data valid
- m_data  output  DWIDTH  stream data (head of skid)
- m_last  output  1  high with the final word of the transfer
- m_ready  input  1  downstream accept

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; busy=0, done=0, buf_rd_en=0, m_valid=0, m_last=0, m_data=0.
  - Counters and skid are cleared.
  - Mid-transfer reset discards any in-flight read word.
  - The buffer pointer is not restored; the system resets the buffer alongside this block.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 latches len into len_q and clears issued_cnt/sent_cnt.
    - len=0: go to FIN (no reads).
    - Otherwise: go to RUN; busy=1 next cycle.
  - RUN: when the final word is accepted (m_valid & m_ready & m_last), go to FIN.
  - FIN: done=1 for exactly one cycle; busy=0 from this cycle; go to IDLE. A start in FIN is ignored.
- Read issue:
  - buf_rd_en = (state==RUN) & (issued_cnt<len_q) & (occ + inflight - pop < 2), where:
    - pop = m_valid & m_ready
    - occ = skid entries (0..2)
    - inflight = 1 if a read was issued last cycle
  - A read counts as issued only when buf_rd_en & !buf_empty. issued_cnt increments on that, and inflight is set for the next cycle.
  - buf_rd_en may be high while buf_empty=1. That is a no-op: no count, no inflight.
- Capture:
  - In the cycle where inflight=1, buf_dout is written into the skid tail.
  - The entry carries last = (capture index == len_q-1).
- Skid:
  - 2-entry FIFO. The head drives m_data/m_last, and m_valid = occ!=0.
  - Simultaneous push and pop is allowed at any occupancy, including occ=2 with pop.
  - The issue rule guarantees no overflow.
  - m_data/m_last hold stable while m_valid & !m_ready.
- Throughput:
  - m_ready held 1 and buffer non-empty gives one word per cycle.
  - First m_valid appears 2 cycles after the first buf_rd_en (issue, capture, present).
- Counters:
  - sent_cnt increments on pop.
  - Counters are LEN_W wide and never wrap, since len ≤ MAX_LEN.
- len > MAX_LEN is out of contract.

Test Plan:
- len=4, buffer preloaded A,B,C,D, m_ready=1: buf_rd_en high 4 cycles; m_data A,B,C,D on consecutive cycles; m_last only with D; done pulses the cycle after the D handshake; busy low the same cycle.
- len=6, m_ready toggling 1,0,0,1…: no word lost or duplicated; m_data stable while stalled; skid occupancy never exceeds 2; exactly 6 buffer pops.
- len=3, buf_empty=1 for 5 cycles then 3 words written: no count during empty; the three words stream out in order; done once.
- start with len=0: no buf_rd_en; done one cycle after entering FIN; m_valid never asserted.
- start pulsed while busy with a different len: ignored; the original transfer completes with the original count.
- rstn dropped mid-transfer after 2 of 5 words: all outputs 0 immediately; after release, start len=2 transfers cleanly.

Source files
------------

// File: rtl/buffer_reader.sv
// Pops len words from a registered-read buffer and streams them out as valid/ready.
// Latency: first m_valid two cycles after the first buf_rd_en; one word per cycle sustained.
// Backpressure: a 2-entry skid absorbs the read latency; reads are issued only when a skid slot is guaranteed.
module buffer_reader #(
    parameter int DWIDTH  = 16,
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              buf_rd_en,
    input  logic [DWIDTH-1:0] buf_dout,
    input  logic              buf_empty,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q, issued_cnt, sent_cnt;
    logic              inflight;
    logic [1:0]        occ;
    logic [1:0]        tgt;
    logic [DWIDTH-1:0] d0, d1;
    logic              l0, l1;
    logic              pop, push, issue, accept, cap_last;

    assign pop     = m_valid & m_ready;
    assign push    = inflight;
    assign issue   = buf_rd_en & ~buf_empty;
    assign accept  = (state == IDLE) & start;
    assign m_valid = (occ != 2'd0);
    assign m_data  = d0;
    assign m_last  = m_valid & l0;
    assign tgt     = occ - {1'b0, pop};

    // issued_cnt already counts the word being captured, so it is the last one when it equals len_q
    assign cap_last = (issued_cnt == len_q);

    // Slot check: entries held plus the word in flight, minus the one leaving this cycle, must stay below 2
    assign buf_rd_en = (state == RUN) && (issued_cnt < len_q) &&
                       (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? FIN : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (pop && m_last) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q      <= '0;
            issued_cnt <= '0;
            sent_cnt   <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept) begin
                len_q      <= len;
                issued_cnt <= '0;
                sent_cnt   <= '0;
            end else begin
                if (issue) issued_cnt <= issued_cnt + LEN_W'(1);
                if (pop)   sent_cnt   <= sent_cnt + LEN_W'(1);
            end
        end
    end

    // Skid: entry 0 is the head; a pop shifts entry 1 forward, a push lands in the first free slot after the pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ <= 2'd0;
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop && occ == 2'd2) begin
                d0 <= d1;
                l0 <= l1;
            end
            if (push) begin
                if (tgt == 2'd0) begin
                    d0 <= buf_dout;
                    l0 <= cap_last;
                end else begin
                    d1 <= buf_dout;
                    l1 <= cap_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader with a registered-read buffer model and a stream monitor.
module tb_buffer_reader;

    localparam int DWIDTH  = 16;
    localparam int MAX_LEN = 256;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy, done, buf_rd_en, buf_empty;
    logic [DWIDTH-1:0] buf_dout;
    logic              m_valid, m_last, m_ready;
    logic [DWIDTH-1:0] m_data;

    buffer_reader #(.DWIDTH(DWIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .busy(busy), .done(done),
        .buf_rd_en(buf_rd_en), .buf_dout(buf_dout), .buf_empty(buf_empty),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Buffer model: registered read, reset alongside the block
    logic [DWIDTH-1:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr;
    int pops = 0;
    logic hold_empty = 1'b0;

    assign buf_empty = hold_empty || (rd_ptr == wr_ptr);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= 0;
            buf_dout <= '0;
        end else if (buf_rd_en && !buf_empty) begin
            buf_dout <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
            pops     <= pops + 1;
        end
    end

    // Stream monitor, sampled mid-cycle
    logic [DWIDTH-1:0] rcv [$];
    logic              rcv_last [$];
    int rd_cnt = 0, done_cnt = 0, valid_cnt = 0, stab_err = 0;
    logic stalled = 1'b0;
    logic [DWIDTH-1:0] st_data;
    logic st_last;

    always @(negedge clk) begin
        if (!rstn) begin
            stalled = 1'b0;
        end else begin
            if (buf_rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (m_valid) begin
                valid_cnt++;
                if (stalled && (m_data !== st_data || m_last !== st_last)) stab_err++;
                if (m_ready) begin
                    rcv.push_back(m_data);
                    rcv_last.push_back(m_last);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    st_data = m_data;
                    st_last = m_last;
                end
            end else begin
                if (stalled) stab_err++;
                stalled = 1'b0;
            end
        end
    end

    int checks = 0, failures = 0;
    logic [DWIDTH-1:0] exp_w [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DWIDTH-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
        exp_w.push_back(w);
    endtask

    task automatic go(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        cyc();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            cyc();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic cmp_stream(input string tag, input int base);
        int n = rcv.size() - base;
        check({tag, "_count"}, n, exp_w.size());
        for (int i = 0; i < exp_w.size() && i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), rcv[base + i], exp_w[i]);
            check($sformatf("%s_last%0d", tag, i), rcv_last[base + i], (i == exp_w.size() - 1));
        end
    endtask

    logic [6:0] e_rd    = 7'b0001111;
    logic [6:0] e_valid = 7'b0111100;
    logic [6:0] e_last  = 7'b0100000;
    logic [6:0] e_busy  = 7'b0111111;
    logic [6:0] e_done  = 7'b1000000;

    initial begin
        int base, p0, d0, r0, v0, n;

        rstn    = 1'b0;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", buf_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();

        // len=4, full rate, cycle-exact
        exp_w.delete();
        load(16'h1111); load(16'h2222); load(16'h3333); load(16'h4444);
        base = rcv.size();
        go(4);
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) cyc();
            check($sformatf("t1_rd_en_c%0d", k), buf_rd_en, e_rd[k-1]);
            check($sformatf("t1_valid_c%0d", k), m_valid, e_valid[k-1]);
            check($sformatf("t1_last_c%0d", k), m_last, e_last[k-1]);
            check($sformatf("t1_busy_c%0d", k), busy, e_busy[k-1]);
            check($sformatf("t1_done_c%0d", k), done, e_done[k-1]);
            if (e_valid[k-1]) check($sformatf("t1_data_c%0d", k), m_data, exp_w[k-3]);
        end
        cyc();
        check("t1_done_cleared", done, 0);
        check("t1_idle_busy", busy, 0);
        cmp_stream("t1", base);

        // len=6 with m_ready pattern 1,0,0,1
        exp_w.delete();
        for (int i = 0; i < 6; i++) load(16'hA000 + 16'(i));
        base = rcv.size();
        p0 = pops;
        go(6);
        for (int c = 0; c < 80 && !done; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            cyc();
        end
        check("t2_done_seen", done, 1);
        m_ready = 1'b1;
        cyc();
        cmp_stream("t2", base);
        check("t2_pops", pops - p0, 6);
        check("t2_stable", stab_err, 0);
        check("t2_occ_max", (dut.occ <= 2'd2), 1);

        // len=3 behind an empty buffer for 5 cycles
        exp_w.delete();
        base = rcv.size();
        p0 = pops;
        d0 = done_cnt;
        hold_empty = 1'b1;
        go(3);
        check("t3_busy", busy, 1);
        for (int i = 0; i < 4; i++) cyc();
        check("t3_rd_en_while_empty", buf_rd_en, 1);
        check("t3_no_pop_while_empty", pops - p0, 0);
        check("t3_no_valid_while_empty", m_valid, 0);
        load(16'hBEE1); load(16'hBEE2); load(16'hBEE3);
        hold_empty = 1'b0;
        wait_done("t3", 30);
        cyc();
        cmp_stream("t3", base);
        check("t3_done_once", done_cnt - d0, 1);

        // len=0: straight to FIN, no reads, no data
        r0 = rd_cnt;
        v0 = valid_cnt;
        go(0);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        cyc();
        check("t4_done_cleared", done, 0);
        cyc();
        check("t4_no_rd_en", rd_cnt - r0, 0);
        check("t4_no_valid", valid_cnt - v0, 0);

        // start while busy is ignored
        exp_w.delete();
        load(16'hC001); load(16'hC002); load(16'hC003);
        base = rcv.size();
        p0 = pops;
        d0 = done_cnt;
        go(3);
        cyc();
        go(5);
        wait_done("t5", 30);
        cyc();
        cmp_stream("t5", base);
        check("t5_pops", pops - p0, 3);
        for (int i = 0; i < 5; i++) cyc();
        check("t5_stays_idle", busy, 0);
        check("t5_done_once", done_cnt - d0, 1);

        // reset mid-transfer after 2 of 5 words
        exp_w.delete();
        for (int i = 0; i < 5; i++) load(16'hD000 + 16'(i));
        base = rcv.size();
        go(5);
        n = 0;
        while (rcv.size() - base < 2 && n < 20) begin
            cyc();
            n++;
        end
        check("t6_two_words_before_reset", (rcv.size() - base >= 2), 1);
        rstn = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_rd_en", buf_rd_en, 0);
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_last", m_last, 0);
        check("t6_rst_data", m_data, 0);
        wr_ptr = 0;
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
        exp_w.delete();
        load(16'hE001); load(16'hE002);
        base = rcv.size();
        go(2);
        wait_done("t6", 30);
        cyc();
        cmp_stream("t6", base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
